// File: rtl/clock_pkg.sv
// clock_pkg
//   Shared constants and types for the 12-hour clock with alarm.
//   - SEC_MAX / MIN_MAX / HR_MAX : terminal counts of the time fields
//   - *_W                        : field widths
//   - alarm_state_t              : alarm FSM encoding
//   - timekeeper_dbg_t           : debug bundle exported by clock_timekeeper
package clock_pkg;

  localparam int SEC_MAX    = 59;
  localparam int MIN_MAX    = 59;
  localparam int HR_MAX     = 11;

  localparam int SEC_W      = 6;
  localparam int MIN_W      = 6;
  localparam int HR_W       = 4;
  localparam int RING_CNT_W = 6;

  typedef enum logic [1:0] {
    AL_OFF     = 2'd0,
    AL_ARMED   = 2'd1,
    AL_RINGING = 2'd2,
    AL_DONE    = 2'd3
  } alarm_state_t;

  typedef struct packed {
    alarm_state_t          state;
    logic [RING_CNT_W-1:0] ring_cnt;
    logic                  beep_phase;
    logic                  half_day_wrap;  // one-cycle flag after 11:59:59 -> 12:00:00
  } timekeeper_dbg_t;

endpackage

// File: rtl/wrap_counter.sv
// wrap_counter
//   Modulo-(MAX+1) up counter used for the seconds, minutes and hours fields.
//   Ports:
//     clk    in   system clock
//     reset  in   synchronous active-high reset, clears count
//     inc    in   advance by one this cycle
//     count  out  registered count value, 0..MAX
//     carry  out  combinational: inc is high and count is at MAX (wraps this edge)
module wrap_counter #(
  parameter int MAX = 59,
  parameter int W   = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         carry
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic at_max;

  assign at_max = (count == MAX_V);
  assign carry  = inc && at_max;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc) begin
      count <= at_max ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/clock_timekeeper.sv
// clock_timekeeper
//   12-hour time of day with a single alarm. Hour value 0 is displayed as 12.
//   Parameters:
//     AL_MIN_STEP   alarm minutes added per al_adj pulse (1..59)
//     RING_SECONDS  ring duration in tick_1hz periods (1..63)
//   Ports:
//     clk, reset                     clock, synchronous active-high reset
//     tick_1hz                       one-cycle pulse per second
//     sec_adj/min_adj/hrs_adj        field-only increments (no carry)
//     al_adj                         advance alarm time by AL_MIN_STEP minutes
//     al_toggle                      arm / disarm the alarm
//     tone_in                        buzzer tone square wave
//     seconds, minutes, hours        current time (registered)
//     al_minutes, al_hours           alarm time (registered)
//     al_on                          alarm armed (bell symbol)
//     alarm                          alarm ringing
//     buzzer_out                     tone gated by ringing and beep phase
//     dbg                            FSM state, ring counter, beep phase, day wrap
//
//   Handshake: every control input is a single-cycle pulse with no back-pressure;
//   a pulse is consumed on the edge that samples it and the effect is visible the
//   following cycle. tick_1hz has priority: adjust pulses in a tick cycle are dropped.
module clock_timekeeper
  import clock_pkg::*;
#(
  parameter int AL_MIN_STEP  = 10,
  parameter int RING_SECONDS = 60
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick_1hz,
  input  logic                  sec_adj,
  input  logic                  min_adj,
  input  logic                  hrs_adj,
  input  logic                  al_adj,
  input  logic                  al_toggle,
  input  logic                  tone_in,
  output logic [SEC_W-1:0]      seconds,
  output logic [MIN_W-1:0]      minutes,
  output logic [HR_W-1:0]       hours,
  output logic [MIN_W-1:0]      al_minutes,
  output logic [HR_W-1:0]       al_hours,
  output logic                  al_on,
  output logic                  alarm,
  output logic                  buzzer_out,
  output timekeeper_dbg_t       dbg
);

  localparam logic [RING_CNT_W-1:0] RING_LAST = RING_CNT_W'(RING_SECONDS - 1);
  localparam logic [HR_W-1:0]       HR_MAX_V  = HR_W'(HR_MAX);

  // ---------------------------------------------------------------------------
  // Time of day
  // ---------------------------------------------------------------------------
  logic adj_ok;
  logic sec_inc, min_inc, hr_inc;
  logic sec_carry, min_carry, hr_carry;
  logic half_day_wrap;

  assign adj_ok = ~tick_1hz;

  // Carries only propagate on the tick path; an adjust wrap never carries.
  assign sec_inc = tick_1hz | (sec_adj & adj_ok);
  assign min_inc = (tick_1hz & sec_carry) | (min_adj & adj_ok);
  assign hr_inc  = (tick_1hz & min_carry) | (hrs_adj & adj_ok);

  wrap_counter #(.MAX(SEC_MAX), .W(SEC_W)) u_sec (
    .clk   (clk),
    .reset (reset),
    .inc   (sec_inc),
    .count (seconds),
    .carry (sec_carry)
  );

  wrap_counter #(.MAX(MIN_MAX), .W(MIN_W)) u_min (
    .clk   (clk),
    .reset (reset),
    .inc   (min_inc),
    .count (minutes),
    .carry (min_carry)
  );

  wrap_counter #(.MAX(HR_MAX), .W(HR_W)) u_hr (
    .clk   (clk),
    .reset (reset),
    .inc   (hr_inc),
    .count (hours),
    .carry (hr_carry)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      half_day_wrap <= 1'b0;
    end else begin
      half_day_wrap <= tick_1hz & hr_carry;
    end
  end

  // ---------------------------------------------------------------------------
  // Alarm time: minutes advance by AL_MIN_STEP and overflow into hours.
  // ---------------------------------------------------------------------------
  logic [MIN_W:0] al_sum;
  logic           al_min_ovf;

  assign al_sum     = {1'b0, al_minutes} + (MIN_W+1)'(AL_MIN_STEP);
  assign al_min_ovf = (al_sum >= (MIN_W+1)'(60));

  always_ff @(posedge clk) begin
    if (reset) begin
      al_minutes <= '0;
      al_hours   <= '0;
    end else if (al_adj && adj_ok) begin
      if (al_min_ovf) begin
        al_minutes <= MIN_W'(al_sum - (MIN_W+1)'(60));
        al_hours   <= (al_hours == HR_MAX_V) ? '0 : al_hours + 1'b1;
      end else begin
        al_minutes <= al_sum[MIN_W-1:0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Alarm FSM
  // ---------------------------------------------------------------------------
  alarm_state_t          state_q, state_d;
  logic [RING_CNT_W-1:0] ring_cnt_q, ring_cnt_d;
  logic                  beep_q, beep_d;
  logic                  al_on_d, alarm_d, buzzer_d;
  logic                  time_match;
  logic                  ring_timeout;
  logic                  ring_entry;

  // Compares the registered time against the registered alarm time, so the
  // match is seen one cycle after the tick that reaches the alarm minute.
  assign time_match   = (hours == al_hours) && (minutes == al_minutes);
  assign ring_timeout = tick_1hz && (ring_cnt_q == RING_LAST);

  // State register (plus the registered outputs derived from next state)
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= AL_OFF;
      ring_cnt_q <= '0;
      beep_q     <= 1'b0;
      al_on      <= 1'b0;
      alarm      <= 1'b0;
      buzzer_out <= 1'b0;
    end else begin
      state_q    <= state_d;
      ring_cnt_q <= ring_cnt_d;
      beep_q     <= beep_d;
      al_on      <= al_on_d;
      alarm      <= alarm_d;
      buzzer_out <= buzzer_d;
    end
  end

  // Next-state logic; al_toggle overrides every other transition.
  always_comb begin
    state_d = state_q;
    if (al_toggle) begin
      state_d = (state_q == AL_OFF) ? AL_ARMED : AL_OFF;
    end else begin
      unique case (state_q)
        AL_OFF:     state_d = AL_OFF;
        AL_ARMED:   if (time_match)   state_d = AL_RINGING;
        AL_RINGING: if (ring_timeout) state_d = AL_DONE;
        AL_DONE:    if (!time_match)  state_d = AL_ARMED;
        default:    state_d = AL_OFF;
      endcase
    end
  end

  // Output / datapath logic. Outputs are decoded from the next state and then
  // registered, so a toggle or timeout silences alarm and buzzer on that edge.
  always_comb begin
    ring_entry = (state_q != AL_RINGING) && (state_d == AL_RINGING);
    ring_cnt_d = ring_cnt_q;
    beep_d     = beep_q;
    if (ring_entry) begin
      ring_cnt_d = '0;
      beep_d     = 1'b1;
    end else if ((state_q == AL_RINGING) && tick_1hz) begin
      ring_cnt_d = ring_cnt_q + 1'b1;
      beep_d     = ~beep_q;
    end
    al_on_d  = (state_d != AL_OFF);
    alarm_d  = (state_d == AL_RINGING);
    buzzer_d = alarm_d & beep_d & tone_in;
  end

  assign dbg.state         = state_q;
  assign dbg.ring_cnt      = ring_cnt_q;
  assign dbg.beep_phase    = beep_q;
  assign dbg.half_day_wrap = half_day_wrap;

endmodule
